// File: rtl/exc_controller_if.sv
// Request/handshake bundle between the exception controller and its datapath.
// The controller connects through the slave modport; the datapath side uses master.
interface exc_controller_if #(
  parameter int unsigned NIRQ = 4
);
  logic [NIRQ-1:0] irq;
  logic [NIRQ-1:0] irq_en;
  logic            BadOp;
  logic            ExcAck;
  logic            ERet;
  logic            Exc;
  logic [3:0]      EStatus;
  logic            busy;
  logic [NIRQ:0]   pending;
  logic            overrun;

  modport master (
    output irq, irq_en, BadOp, ExcAck, ERet,
    input  Exc, EStatus, busy, pending, overrun
  );

  modport slave (
    input  irq, irq_en, BadOp, ExcAck, ERet,
    output Exc, EStatus, busy, pending, overrun
  );
endinterface

// File: rtl/exc_controller.sv
// Single-level exception controller: latches BadOp and irq rising edges as pending
// causes, dispatches the highest-priority eligible one, and tracks the ack/return handshake.
module exc_controller #(
  parameter int unsigned NIRQ = 4
) (
  input  logic            clk,
  input  logic            reset,
  exc_controller_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [NIRQ-1:0] irq_prev_q;
  logic [NIRQ:0]   pending_q, pending_d;
  logic [NIRQ:0]   events;
  logic [NIRQ:0]   eligible;
  logic [NIRQ:0]   grant;
  logic [NIRQ:0]   clr;
  logic [3:0]      estatus_q, estatus_d;
  logic [3:0]      win_code;
  logic            exc_q;
  logic            overrun_q, overrun_d;
  logic            any_elig;
  logic            dispatch;
  logic            found;

  // Bit 0 is BadOp (never masked); bit i+1 is irq[i].
  assign events   = {bus.irq & ~irq_prev_q, bus.BadOp};
  assign eligible = pending_q & {bus.irq_en, 1'b1};
  assign any_elig = |eligible;

  // Lowest index wins; the cause code of bit j is simply j+1.
  always_comb begin : arbiter
    grant    = '0;
    win_code = '0;
    found    = 1'b0;
    for (int unsigned j = 0; j <= NIRQ; j++) begin
      if (eligible[j] && !found) begin
        grant[j] = 1'b1;
        win_code = 4'(j + 1);
        found    = 1'b1;
      end
    end
  end

  always_comb begin : fsm_next
    state_d   = state_q;
    estatus_d = estatus_q;
    dispatch  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (any_elig) begin
          state_d   = REQ;
          estatus_d = win_code;
          dispatch  = 1'b1;
        end
      end
      REQ: begin
        if (bus.ExcAck) state_d = SERVICE;
      end
      SERVICE: begin
        if (bus.ERet) begin
          state_d   = IDLE;
          estatus_d = '0;
        end
      end
      default: begin
        state_d   = IDLE;
        estatus_d = '0;
      end
    endcase
  end

  // A new event on the bit being dispatched re-arms it without counting as overrun.
  always_comb begin : pending_next
    clr       = dispatch ? grant : '0;
    pending_d = (pending_q & ~clr) | events;
    overrun_d = overrun_q | (|(events & pending_q & ~clr));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      irq_prev_q <= '0;
      pending_q  <= '0;
      estatus_q  <= '0;
      exc_q      <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      irq_prev_q <= bus.irq;
      pending_q  <= pending_d;
      estatus_q  <= estatus_d;
      exc_q      <= (state_d == REQ);
      overrun_q  <= overrun_d;
    end
  end

  assign bus.Exc     = exc_q;
  assign bus.EStatus = estatus_q;
  assign bus.busy    = (state_q != IDLE);
  assign bus.pending = pending_q;
  assign bus.overrun = overrun_q;

endmodule
